// File: rtl/baton_pkg.sv
// Shared types and constants for the baton/tempo pipeline.
// Holds the beat tracker state encoding plus the period width and the
// default accepted beat window, so the playback side agrees on the same
// limits.
package baton_pkg;

  localparam int PERIOD_W      = 16;
  localparam int MIN_PERIOD_MS = 250;   // 240 BPM
  localparam int MAX_PERIOD_MS = 2000;  // 30 BPM

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    TRACK
  } beat_state_t;

endpackage

// File: rtl/beat_period_tracker_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler.
// Counts 0..CYCLES_PER_MS-1 and produces a one-cycle tick on the last count.
// A synchronous clear restarts the millisecond so that beat intervals are
// measured from the accepted beat edge.
//   clk_camera_in  system clock
//   rst_in         asynchronous active-high reset
//   clear          restart the prescaler (suppresses the tick this cycle)
//   tick           one-cycle millisecond strobe
module ms_tick_gen #(
  parameter int CYCLES_PER_MS = 65_000
) (
  input  logic clk_camera_in,
  input  logic rst_in,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_MS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = ~clear & (count == LAST);

endmodule

// File: rtl/beat_period_tracker.sv
// beat_period_tracker: turns the baton tracker's per-frame beat pulse into a
// musical timeline (beat strobes, smoothed beat period in ms, beat position
// within the measure).
//   clk_camera_in         system clock
//   rst_in                asynchronous active-high reset
//   change_in             beat indication, may stay high for several cycles
//   beats_per_measure_in  time-signature numerator (0 behaves as 1)
//   beat_valid_out        one-cycle strobe per accepted beat
//   downbeat_out          strobe with beat_valid_out when the index wraps to 0
//   beat_index_out        position of the last accepted beat in the measure
//   period_out            smoothed beat period in ms, 0 while unlocked
//   last_interval_out     raw interval of the last accepted beat in ms
//   locked_out            two beats inside the valid window have been seen
//
// state | meaning
// IDLE  | no reference beat; any rising edge starts a new timeline
// FIRST | one beat seen; next in-window beat gives the first period
// TRACK | locked; in-window beats refine the period by exponential average
module beat_period_tracker #(
  parameter int CLK_FREQ_HZ   = 65_000_000,
  parameter int MIN_PERIOD_MS = baton_pkg::MIN_PERIOD_MS,
  parameter int MAX_PERIOD_MS = baton_pkg::MAX_PERIOD_MS,
  parameter int AVG_SHIFT     = 2,
  parameter int PERIOD_W      = baton_pkg::PERIOD_W
) (
  input  logic                clk_camera_in,
  input  logic                rst_in,
  input  logic                change_in,
  input  logic [2:0]          beats_per_measure_in,
  output logic                beat_valid_out,
  output logic                downbeat_out,
  output logic [2:0]          beat_index_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic [PERIOD_W-1:0] last_interval_out,
  output logic                locked_out
);

  import baton_pkg::*;

  localparam int CYCLES_PER_MS = CLK_FREQ_HZ / 1000;
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD_MS);
  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD_MS);
  localparam logic [PERIOD_W-1:0] SAT_P = PERIOD_W'(MAX_PERIOD_MS + 1);
  localparam logic signed [PERIOD_W+1:0] MIN_S = (PERIOD_W+2)'(MIN_PERIOD_MS);
  localparam logic signed [PERIOD_W+1:0] MAX_S = (PERIOD_W+2)'(MAX_PERIOD_MS);

  beat_state_t         state_q, state_d;
  logic                change_q;
  logic                rise;
  logic                ms_tick;
  logic                beat_clear;
  logic [PERIOD_W-1:0] ms_count;
  logic [2:0]          bpm_q, bpm_d, bpm_eff;
  logic [2:0]          idx_next;
  logic                in_window, timeout, first_beat;

  logic                valid_d, down_d, locked_d;
  logic [2:0]          idx_d;
  logic [PERIOD_W-1:0] period_d, last_d;

  logic signed [PERIOD_W:0]   avg_diff, avg_step;
  logic signed [PERIOD_W+1:0] avg_sum;
  logic [PERIOD_W-1:0]        avg_clamped;

  ms_tick_gen #(
    .CYCLES_PER_MS(CYCLES_PER_MS)
  ) u_ms_tick_gen (
    .clk_camera_in(clk_camera_in),
    .rst_in       (rst_in),
    .clear        (beat_clear),
    .tick         (ms_tick)
  );

  assign rise      = change_in & ~change_q;
  assign in_window = (ms_count >= MIN_P) && (ms_count <= MAX_P);
  assign timeout   = (ms_count == SAT_P);
  assign bpm_eff   = (beats_per_measure_in == 3'd0) ? 3'd1 : beats_per_measure_in;
  // >= rather than == so an index beyond a shortened measure still wraps.
  assign idx_next  = (beat_index_out >= bpm_q - 3'd1) ? 3'd0 : beat_index_out + 3'd1;

  // Signed difference with an arithmetic shift floors negative steps,
  // e.g. 525 -> 400 moves by -32, not -31.
  always_comb begin
    avg_diff = $signed({1'b0, ms_count}) - $signed({1'b0, period_out});
    avg_step = avg_diff >>> AVG_SHIFT;
    avg_sum  = $signed({2'b00, period_out}) + $signed({avg_step[PERIOD_W], avg_step});
    if (avg_sum < MIN_S) begin
      avg_clamped = MIN_P;
    end else if (avg_sum > MAX_S) begin
      avg_clamped = MAX_P;
    end else begin
      avg_clamped = avg_sum[PERIOD_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = 1'b0;
    down_d     = 1'b0;
    idx_d      = beat_index_out;
    period_d   = period_out;
    last_d     = last_interval_out;
    locked_d   = locked_out;
    bpm_d      = bpm_q;
    beat_clear = 1'b0;
    first_beat = 1'b0;

    case (state_q)
      IDLE: begin
        first_beat = rise;
      end
      FIRST, TRACK: begin
        if (timeout) begin
          // A rise arriving on the timeout cycle restarts the timeline.
          state_d    = IDLE;
          locked_d   = 1'b0;
          period_d   = '0;
          idx_d      = 3'd0;
          first_beat = rise;
        end else if (rise && in_window) begin
          valid_d    = 1'b1;
          beat_clear = 1'b1;
          idx_d      = idx_next;
          last_d     = ms_count;
          if (idx_next == 3'd0) begin
            down_d = 1'b1;
            bpm_d  = bpm_eff;
          end
          if (state_q == FIRST) begin
            period_d = ms_count;
            locked_d = 1'b1;
            state_d  = TRACK;
          end else begin
            period_d = avg_clamped;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (first_beat) begin
      state_d    = FIRST;
      valid_d    = 1'b1;
      down_d     = 1'b1;
      idx_d      = 3'd0;
      bpm_d      = bpm_eff;
      beat_clear = 1'b1;
    end
  end

  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      state_q           <= IDLE;
      change_q          <= 1'b0;
      bpm_q             <= 3'd0;
      beat_valid_out    <= 1'b0;
      downbeat_out      <= 1'b0;
      beat_index_out    <= 3'd0;
      period_out        <= '0;
      last_interval_out <= '0;
      locked_out        <= 1'b0;
    end else begin
      state_q           <= state_d;
      change_q          <= change_in;
      bpm_q             <= bpm_d;
      beat_valid_out    <= valid_d;
      downbeat_out      <= down_d;
      beat_index_out    <= idx_d;
      period_out        <= period_d;
      last_interval_out <= last_d;
      locked_out        <= locked_d;
    end
  end

  // Saturates one past the window so the timeout condition stays visible.
  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      ms_count <= '0;
    end else if (beat_clear) begin
      ms_count <= '0;
    end else if (ms_tick && ms_count != SAT_P) begin
      ms_count <= ms_count + 1'b1;
    end
  end

endmodule
